// File: rtl/cheri_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cheri_pkg
// Description : Shared types for the CHERI tsmap arbiter: arbiter FSM state
//               encoding, bus operation encoding and the read-modify-write
//               word helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cheri_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_RSP  = 3'd4
    } tsmap_state_e;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_SET   = 2'b01,
        OP_CLR   = 2'b10,
        OP_READ  = 2'b11
    } bus_op_e;

    // Word that the WR state commits for a given operation.
    function automatic logic [31:0] tsmap_modify(
        input bus_op_e     op,
        input logic [31:0] word,
        input logic [4:0]  bitpos,
        input logic [31:0] wdata
    );
        logic [31:0] mask;
        mask = 32'd1 << bitpos;
        case (op)
            OP_SET:  tsmap_modify = word | mask;
            OP_CLR:  tsmap_modify = word & ~mask;
            default: tsmap_modify = wdata;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/cheri_tsmap_arb.sv
`default_nettype none
// ============================================================================
// Module      : cheri_tsmap_arb
// Description : Arbitrates a single-port revocation-map SRAM between the
//               revocation pipeline stage (absolute priority, never stalled)
//               and a bus port offering word write, bit set, bit clear and
//               word read. Bit operations are read-modify-write. A pending
//               write is forwarded to revocation reads of the same address.
//               Optional macro CHERI_TSMAP_PERFCNT_EN enables the stall
//               counter on perf_stall_cnt_o; otherwise it reads 0.
// Revision    : 1.0 - initial release
// ============================================================================
module cheri_tsmap_arb
    import cheri_pkg::*;
#(
    parameter int unsigned TSMapSize = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        trvk_cs_i,
    input  logic [15:0] trvk_addr_i,
    output logic [31:0] trvk_rdata_o,

    input  logic        bus_req_i,
    input  logic [1:0]  bus_op_i,
    input  logic [15:0] bus_addr_i,
    input  logic [4:0]  bus_bitpos_i,
    input  logic [31:0] bus_wdata_i,
    output logic        bus_gnt_o,
    output logic        bus_rvalid_o,
    output logic [31:0] bus_rdata_o,
    output logic        bus_err_o,

    output logic        mem_cs_o,
    output logic        mem_we_o,
    output logic [15:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,

    output logic        busy_o,

    input  logic        perf_clr_i,
    output logic [15:0] perf_stall_cnt_o
);

    // 17 bits so a map covering the full 16-bit address space still compares correctly.
    localparam logic [16:0] MAP_LIMIT = 17'(TSMapSize);

    tsmap_state_e state_q, state_d;
    bus_op_e      op_q;
    logic [15:0]  addr_q;
    logic [4:0]   bitpos_q;
    logic [31:0]  wdata_q;
    logic         err_q;
    logic [31:0]  cap_q;
    logic         fwd_q;
    logic [31:0]  fwd_data_q;

    logic         latch_en;
    logic         cap_en;
    logic         addr_oob;
    logic         fwd_hit;
    logic [31:0]  mod_word;

    assign addr_oob = {1'b0, bus_addr_i} >= MAP_LIMIT;
    assign mod_word = tsmap_modify(op_q, cap_q, bitpos_q, wdata_q);
    assign fwd_hit  = (state_q == ST_WR) && trvk_cs_i && (trvk_addr_i == addr_q);
    assign busy_o   = (state_q != ST_IDLE);

    // A stalled write leaves the SRAM stale for one cycle, so serve the pending word instead.
    assign trvk_rdata_o = fwd_q ? fwd_data_q : mem_rdata_i;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, bus handshake and SRAM port steering; the revocation stage owns the port whenever it asks.
    always_comb begin
        state_d      = state_q;
        bus_gnt_o    = 1'b0;
        bus_rvalid_o = 1'b0;
        bus_err_o    = 1'b0;
        bus_rdata_o  = 32'd0;
        mem_cs_o     = trvk_cs_i;
        mem_we_o     = 1'b0;
        mem_addr_o   = trvk_addr_i;
        mem_wdata_o  = 32'd0;
        latch_en     = 1'b0;
        cap_en       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus_req_i) begin
                    bus_gnt_o = 1'b1;
                    latch_en  = 1'b1;
                    if (addr_oob) begin
                        state_d = ST_RSP;
                    end else if (bus_op_e'(bus_op_i) == OP_WRITE) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (!trvk_cs_i) begin
                    mem_cs_o   = 1'b1;
                    mem_addr_o = addr_q;
                    state_d    = ST_CAP;
                end
            end
            ST_CAP: begin
                cap_en  = 1'b1;
                state_d = (op_q == OP_READ) ? ST_RSP : ST_WR;
            end
            ST_WR: begin
                if (!trvk_cs_i) begin
                    mem_cs_o    = 1'b1;
                    mem_we_o    = 1'b1;
                    mem_addr_o  = addr_q;
                    mem_wdata_o = mod_word;
                    state_d     = ST_RSP;
                end
            end
            ST_RSP: begin
                bus_rvalid_o = 1'b1;
                bus_err_o    = err_q;
                bus_rdata_o  = ((op_q == OP_READ) && !err_q) ? cap_q : 32'd0;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request latch and read-data capture.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q     <= OP_WRITE;
            addr_q   <= 16'd0;
            bitpos_q <= 5'd0;
            wdata_q  <= 32'd0;
            err_q    <= 1'b0;
            cap_q    <= 32'd0;
        end else begin
            if (latch_en) begin
                op_q     <= bus_op_e'(bus_op_i);
                addr_q   <= bus_addr_i;
                bitpos_q <= bus_bitpos_i;
                wdata_q  <= bus_wdata_i;
                err_q    <= addr_oob;
            end
            if (cap_en) begin
                cap_q <= mem_rdata_i;
            end
        end
    end

    // Forward flag and data, aligned with the SRAM's one-cycle read latency.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fwd_q      <= 1'b0;
            fwd_data_q <= 32'd0;
        end else begin
            fwd_q <= fwd_hit;
            if (fwd_hit) begin
                fwd_data_q <= mod_word;
            end
        end
    end

`ifdef CHERI_TSMAP_PERFCNT_EN
    logic [15:0] stall_cnt_q;
    logic        stall_cycle;

    assign stall_cycle      = ((state_q == ST_RD) || (state_q == ST_WR)) && trvk_cs_i;
    assign perf_stall_cnt_o = stall_cnt_q;

    // Saturating count of bus cycles lost to the revocation stage; clear wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= 16'd0;
        end else if (perf_clr_i) begin
            stall_cnt_q <= 16'd0;
        end else if (stall_cycle && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end
`else
    logic unused_perf_clr;
    assign unused_perf_clr  = perf_clr_i;
    assign perf_stall_cnt_o = 16'd0;
`endif

endmodule
`default_nettype wire

// File: doc/cheri_tsmap_arb.md
CHERI_TSMAP_ARB -- requirements
Module: cheri_tsmap_arb

Interface
REQ-001 SHALL have parameter TSMapSize, default 1024, number of 32-bit words in the revocation (tsmap) SRAM.
REQ-002 SHALL have port clk_i input 1: clock.
REQ-003 SHALL have port rst_ni input 1: reset, asynchronous, active-low.
REQ-004 SHALL have port trvk_cs_i input 1: revocation-stage read request; never stalled.
REQ-005 SHALL have port trvk_addr_i input 16: revocation-stage word address.
REQ-006 SHALL have port trvk_rdata_o output 32: read data, valid the cycle after trvk_cs_i.
REQ-007 SHALL have port bus_req_i input 1: bus request; bus_op_i, bus_addr_i, bus_bitpos_i and bus_wdata_i are held stable until granted.
REQ-008 SHALL have port bus_op_i input 2: 00 word write, 01 bit set, 10 bit clear, 11 word read.
REQ-009 SHALL have ports bus_addr_i input 16 (word address), bus_bitpos_i input 5 (bit index), bus_wdata_i input 32 (write data).
REQ-010 SHALL have port bus_gnt_o output 1: one-cycle request acceptance.
REQ-011 SHALL have ports bus_rvalid_o output 1 (one-cycle completion pulse), bus_rdata_o output 32 (read data), bus_err_o output 1 (error, qualified by bus_rvalid_o).
REQ-012 SHALL have ports mem_cs_o output 1, mem_we_o output 1, mem_addr_o output 16, mem_wdata_o output 32 and mem_rdata_i input 32: single-port SRAM with 1-cycle read latency.
REQ-013 SHALL have port busy_o output 1: FSM not IDLE.
REQ-014 SHALL have ports perf_clr_i input 1 and perf_stall_cnt_o output 16: stall counter (see Configuration).

Function
REQ-015 SHALL implement FSM states IDLE, RD, CAP, WR, RSP.
REQ-016 IDLE with bus_req_i SHALL assert bus_gnt_o and latch op/addr/bitpos/wdata; op 00 goes to WR, ops 01/10/11 go to RD; addr >= TSMapSize goes to RSP with error and no memory access.
REQ-017 RD SHALL issue a read (mem_cs_o=1, mem_we_o=0) when trvk_cs_i=0, then go to CAP; otherwise it holds.
REQ-018 CAP SHALL capture mem_rdata_i and make no memory access; op 11 goes to RSP, ops 01/10 go to WR.
REQ-019 The modified word SHALL be: captured word OR (1<<bitpos) for op 01, captured word AND ~(1<<bitpos) for op 10, latched wdata for op 00.
REQ-020 WR SHALL issue a write of the modified word when trvk_cs_i=0, then go to RSP; otherwise it holds.
REQ-021 RSP SHALL pulse bus_rvalid_o; bus_rdata_o SHALL be the captured word for op 11 and 0 otherwise; the state then returns to IDLE.
REQ-022 trvk_cs_i SHALL always win the memory port combinationally: mem_addr_o=trvk_addr_i, read, same cycle.
REQ-023 Uncontended latency: op 01/10 SHALL grant at cycle 0 and pulse rvalid at cycle 4; op 11 at cycle 3; op 00 at cycle 2.
REQ-024 Forwarding: when state=WR and trvk_cs_i is high with trvk_addr_i equal to the latched address, trvk_rdata_o in the next cycle SHALL be the modified word, not mem_rdata_i.
REQ-025 In all other cases trvk_rdata_o SHALL equal mem_rdata_i.
REQ-026 Only one bus transaction SHALL be outstanding; bus_gnt_o SHALL be 0 outside IDLE.

Reset
REQ-027 While rst_ni is low, the FSM SHALL enter IDLE and all outputs and latched registers SHALL go to 0, including the forward flag and the counter.
REQ-028 Reset mid-transaction SHALL abandon the transaction with no memory write and no rvalid.

Configuration
REQ-029 With CHERI_TSMAP_PERFCNT_EN defined, perf_stall_cnt_o SHALL count cycles in RD or WR with trvk_cs_i=1, saturate at 16'hFFFF, and clear synchronously on perf_clr_i (clear has priority).
REQ-030 Without CHERI_TSMAP_PERFCNT_EN, perf_stall_cnt_o SHALL be tied to 0 and perf_clr_i ignored.

Structure
REQ-031 The FSM state enum and the bus_op encoding typedef SHALL live in cheri_pkg.
REQ-032 The block SHALL be a single module with no sub-modules.

Verification
REQ-033 Bit set, addr 5, bit 3, mem word 0x0 -> write 0x00000008 to addr 5; rvalid at cycle 4; err 0.
REQ-034 Bit clear, addr 7, bit 31, word 0xFFFFFFFF, trvk_cs_i high for 3 cycles during RD -> read delayed 3 cycles; write 0x7FFFFFFF; stall count 3.
REQ-035 WR pending for addr 9 with value 0x10 while trvk reads addr 9 -> next-cycle trvk_rdata_o = 0x10.
REQ-036 Read at addr = TSMapSize -> no mem_cs_o; rvalid with err=1 at cycle 1.
REQ-037 Word read at addr 2 holding 0xA5A5A5A5 -> bus_rdata_o = 0xA5A5A5A5 at cycle 3.
REQ-038 rst_ni low during CAP -> no write issued; IDLE; busy_o = 0.
